// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of an incoming 0x55 sync character
// on the rx line and produces a 16x-oversampling divisor (one tick every
// div clocks), matching the meaning of the baud generator's CNT value.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   en         level; 1 = arm/keep measuring, 0 = abort/idle
//   rx         asynchronous serial line, idle high
//   busy       1 while arming, hunting for the start bit or measuring
//   locked     div holds a valid measurement
//   div_valid  one-clock pulse when a new div is loaded
//   err        one-clock pulse on measurement failure
//   div        measured tick period in clocks (CNT_W-7 bits)
module uart_autobaud #(
  parameter int CNT_W    = 20,
  parameter int IDLE_CYC = 16,
  parameter int MIN_DIV  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx,
  output logic             busy,
  output logic             locked,
  output logic             div_valid,
  output logic             err,
  output logic [CNT_W-8:0] div
);

  localparam int DIV_W  = CNT_W - 7;
  localparam int IDLE_W = $clog2(IDLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_HUNT    = 3'd2,
    ST_MEASURE = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  // rx synchronizer and previous-sample register for edge detection
  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic fe_s;

  state_t state_r;
  state_t state_s;

  logic [IDLE_W-1:0] idle_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_s;
  logic [IDLE_W-1:0] idle_inc_s;
  logic [CNT_W-1:0]  total_r;
  logic [CNT_W-1:0]  total_s;
  logic [CNT_W-1:0]  seg_r;
  logic [CNT_W-1:0]  seg_s;
  logic [CNT_W-1:0]  ref_r;
  logic [CNT_W-1:0]  ref_s;
  logic [2:0]        edge_cnt_r;
  logic [2:0]        edge_cnt_s;

  logic [CNT_W-1:0]  total_inc_s;
  logic [CNT_W-1:0]  seg_inc_s;
  logic [CNT_W-1:0]  seg_diff_s;
  logic              seg_bad_s;
  logic [CNT_W-1:0]  round_sum_s;
  logic [DIV_W-1:0]  d_s;
  logic              d_small_s;
  logic              timeout_s;

  logic              busy_s;
  logic              locked_s;
  logic              div_valid_s;
  logic              err_s;
  logic [DIV_W-1:0]  div_s;

  // Two-flop synchronizer plus one more sample for falling-edge detection.
  // All three reset high so that reset release never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign fe_s = prev_r & ~sync2_r;

  // Datapath helpers. seg_inc_s is the interval ending on this clock, since
  // seg restarts at 1 right after an edge.
  assign idle_inc_s  = idle_cnt_r + IDLE_W'(1);
  assign total_inc_s = total_r + CNT_W'(1);
  assign seg_inc_s   = seg_r + CNT_W'(1);
  // Ordered subtraction keeps |seg-ref| free of wrap-around.
  assign seg_diff_s  = (seg_inc_s >= ref_r) ? (seg_inc_s - ref_r) : (ref_r - seg_inc_s);
  assign seg_bad_s   = seg_diff_s > (ref_r >> 2);
  // 8 bit-times = 128 ticks; +64 rounds to nearest before the divide.
  assign round_sum_s = total_inc_s + CNT_W'(64);
  assign d_s         = DIV_W'(round_sum_s >> 7);
  assign d_small_s   = d_s < DIV_W'(MIN_DIV);
  assign timeout_s   = total_inc_s == {CNT_W{1'b1}};

  // Next-state, datapath and output logic of the measurement FSM.
  always_comb begin
    state_s     = state_r;
    idle_cnt_s  = idle_cnt_r;
    total_s     = total_r;
    seg_s       = seg_r;
    ref_s       = ref_r;
    edge_cnt_s  = edge_cnt_r;
    locked_s    = locked;
    div_s       = div;
    div_valid_s = 1'b0;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_s    = ST_ARM;
          locked_s   = 1'b0;
          idle_cnt_s = {IDLE_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ARM: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else if (sync2_r) begin
          if (idle_inc_s == IDLE_W'(IDLE_CYC)) begin
            state_s    = ST_HUNT;
            idle_cnt_s = {IDLE_W{1'b0}};
          end else begin
            idle_cnt_s = idle_inc_s;
          end
        end else begin
          idle_cnt_s = {IDLE_W{1'b0}};
        end
      end

      ST_HUNT: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else if (fe_s) begin
          state_s    = ST_MEASURE;
          total_s    = {CNT_W{1'b0}};
          seg_s      = {CNT_W{1'b0}};
          ref_s      = {CNT_W{1'b0}};
          edge_cnt_s = 3'd0;
        end else begin
          state_s = ST_HUNT;
        end
      end

      ST_MEASURE: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else begin
          total_s = total_inc_s;
          seg_s   = seg_inc_s;
          // Timeout is checked first so it wins over a coincident edge.
          if (timeout_s) begin
            err_s      = 1'b1;
            state_s    = ST_ARM;
            idle_cnt_s = {IDLE_W{1'b0}};
          end else if (fe_s) begin
            edge_cnt_s = edge_cnt_r + 3'd1;
            seg_s      = CNT_W'(1);
            case (edge_cnt_r)
              3'd0: begin
                ref_s = seg_inc_s;
              end
              3'd1, 3'd2: begin
                if (seg_bad_s) begin
                  err_s      = 1'b1;
                  state_s    = ST_ARM;
                  idle_cnt_s = {IDLE_W{1'b0}};
                end else begin
                  state_s = ST_MEASURE;
                end
              end
              3'd3: begin
                if (seg_bad_s || d_small_s) begin
                  err_s      = 1'b1;
                  state_s    = ST_ARM;
                  idle_cnt_s = {IDLE_W{1'b0}};
                end else begin
                  div_s       = d_s;
                  div_valid_s = 1'b1;
                  locked_s    = 1'b1;
                  state_s     = ST_LOCKED;
                end
              end
              default: begin
                err_s      = 1'b1;
                state_s    = ST_ARM;
                idle_cnt_s = {IDLE_W{1'b0}};
              end
            endcase
          end else begin
            state_s = ST_MEASURE;
          end
        end
      end

      ST_LOCKED: begin
        if (!en) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOCKED;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_ARM) || (state_s == ST_HUNT) || (state_s == ST_MEASURE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      idle_cnt_r <= {IDLE_W{1'b0}};
      total_r    <= {CNT_W{1'b0}};
      seg_r      <= {CNT_W{1'b0}};
      ref_r      <= {CNT_W{1'b0}};
      edge_cnt_r <= 3'd0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      div_valid  <= 1'b0;
      err        <= 1'b0;
      div        <= {DIV_W{1'b0}};
    end else begin
      state_r    <= state_s;
      idle_cnt_r <= idle_cnt_s;
      total_r    <= total_s;
      seg_r      <= seg_s;
      ref_r      <= ref_s;
      edge_cnt_r <= edge_cnt_s;
      busy       <= busy_s;
      locked     <= locked_s;
      div_valid  <= div_valid_s;
      err        <= err_s;
      div        <= div_s;
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud. Expected measurement outcomes are
// queued when a sync character is sent and compared when the DUT pulses
// div_valid or err. A second instance with CNT_W=12 covers the timeout.
module tb_uart_autobaud;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rx;
  logic        busy;
  logic        locked;
  logic        div_valid;
  logic        err;
  logic [12:0] div;

  logic        en_t;
  logic        rx_t;
  logic        busy_t;
  logic        locked_t;
  logic        div_valid_t;
  logic        err_t;
  logic [4:0]  div_t;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        exp_err;
    logic [12:0] exp_div;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic last_evt = 1'b0;

  uart_autobaud dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rx        (rx),
    .busy      (busy),
    .locked    (locked),
    .div_valid (div_valid),
    .err       (err),
    .div       (div)
  );

  uart_autobaud #(.CNT_W(12), .IDLE_CYC(16), .MIN_DIV(2)) dut_t (
    .clk       (clk),
    .rst       (rst),
    .en        (en_t),
    .rx        (rx_t),
    .busy      (busy_t),
    .locked    (locked_t),
    .div_valid (div_valid_t),
    .err       (err_t),
    .div       (div_t)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit; extra clocks added to one frame slot.
  task automatic send_frame(input logic [7:0] b, input int bit_clk, input int extra_pos, input int extra);
    for (int pos = 0; pos < 10; pos++) begin
      if (pos == 0) rx = 1'b0;
      else if (pos == 9) rx = 1'b1;
      else rx = b[pos-1];
      idle(bit_clk + ((pos == extra_pos) ? extra : 0));
    end
  endtask

  task automatic expect_evt(input logic e_err, input logic [12:0] e_div);
    exp_t e;
    e.exp_err = e_err;
    e.exp_div = e_div;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic rearm();
    en = 1'b0;
    idle(2);
    en = 1'b1;
    idle(32);
  endtask

  // Output monitor: pairs every div_valid/err pulse with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (last_evt) check_eq("pulse_width", {30'd0, div_valid, err}, 32'd0);
    last_evt = div_valid | err;
    if (div_valid | err) begin
      check_eq("evt_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check_eq("evt_err", err, mon_e.exp_err);
        check_eq("evt_valid", div_valid, !mon_e.exp_err);
        check_eq("evt_div", div, mon_e.exp_div);
        check_eq("evt_locked", locked, !mon_e.exp_err);
        if (err) check_eq("err_back_to_arm", busy, 1);
      end
    end
  end

  initial begin
    int err_early;
    rst = 1'b1;
    en = 1'b0;
    rx = 1'b1;
    en_t = 1'b0;
    rx_t = 1'b1;
    idle(5);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_valid", div_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_div", div, 0);
    rst = 1'b0;
    idle(3);

    // Lock at 160 clk/bit: 1280 clocks over 8 bits -> div 10
    en = 1'b1;
    idle(32);
    expect_evt(1'b0, 13'd10);
    send_frame(8'h55, 160, -1, 0);
    idle(20);
    drain("lock160_drain", 2000);
    check_eq("lock160_locked", locked, 1);
    check_eq("lock160_busy", busy, 0);
    en = 1'b0;
    idle(2);
    check_eq("lock160_idle_busy", busy, 0);
    check_eq("lock160_idle_div", div, 10);
    check_eq("lock160_idle_locked", locked, 1);

    // Re-arm clears locked; then lock at 352 clk/bit -> (2816+64)>>7 = 22
    en = 1'b1;
    idle(2);
    check_eq("rearm_locked", locked, 0);
    check_eq("rearm_busy", busy, 1);
    idle(32);
    expect_evt(1'b0, 13'd22);
    send_frame(8'h55, 352, -1, 0);
    idle(20);
    drain("lock352_drain", 4000);
    check_eq("lock352_locked", locked, 1);

    // E2-E3 stretched to 420 (ref 320, tolerance 80) -> err, div kept at 22
    rearm();
    expect_evt(1'b1, 13'd22);
    send_frame(8'h55, 160, 4, 100);
    drain("tol_drain", 2000);
    check_eq("tol_div_kept", div, 22);
    rearm();
    expect_evt(1'b0, 13'd10);
    send_frame(8'h55, 160, -1, 0);
    idle(20);
    drain("tol_relock_drain", 2000);

    // Too fast: 8 clk/bit gives d=1 < MIN_DIV
    rearm();
    expect_evt(1'b1, 13'd10);
    send_frame(8'h55, 8, -1, 0);
    idle(40);
    drain("fast_drain", 500);
    check_eq("fast_div", div, 10);
    check_eq("fast_locked", locked, 0);

    // Abort after E2: no event at all
    fork
      send_frame(8'h55, 160, -1, 0);
      begin
        idle(4 * 160 + 40);
        en = 1'b0;
      end
    join
    idle(200);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_q", sb_q.size(), 0);

    // rx low at arm; a 15-clock high must not reach HUNT, so the glitch is ignored
    rx = 1'b0;
    idle(2);
    en = 1'b1;
    idle(50);
    check_eq("lowarm_busy", busy, 1);
    rx = 1'b1;
    idle(15);
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    expect_evt(1'b0, 13'd10);
    send_frame(8'h55, 160, -1, 0);
    idle(20);
    drain("lowarm_drain", 2000);
    check_eq("lowarm_locked", locked, 1);

    // Reset in the middle of a measurement
    rearm();
    fork
      send_frame(8'h55, 160, -1, 0);
      begin
        idle(3 * 160 + 10);
        rst = 1'b1;
        idle(1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_valid", div_valid, 0);
        check_eq("midrst_err", err, 0);
        check_eq("midrst_div", div, 0);
        rst = 1'b0;
      end
    join
    en = 1'b0;
    idle(20);
    check_eq("midrst_q", sb_q.size(), 0);

    // Timeout on the 12-bit instance: err exactly 4095 clocks after E0 detection
    en_t = 1'b1;
    idle(30);
    rx_t = 1'b0;
    err_early = 0;
    for (int k = 1; k <= 4099; k++) begin
      @(posedge clk);
      #1;
      if (k < 4098 && err_t) err_early++;
      if (k == 4098) begin
        check_eq("to_err", err_t, 1);
        check_eq("to_locked", locked_t, 0);
        check_eq("to_busy", busy_t, 1);
        check_eq("to_valid", div_valid_t, 0);
      end
      if (k == 4099) check_eq("to_err_pulse", err_t, 0);
    end
    check_eq("to_early", err_early, 0);
    @(negedge clk);
    en_t = 1'b0;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
